// File: rtl/draw_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package     : draw_pkg                                                     |
// | Description : Shared types and constants for the VGA draw scheduler:      |
// |               phase state encoding, pixel field widths, screen size and    |
// |               the packed frame-buffer write record.                        |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package draw_pkg;

  localparam int X_W     = 8;
  localparam int Y_W     = 8;
  localparam int COLOR_W = 12;

  localparam int H_PIX   = 160;
  localparam int V_PIX   = 120;

  // Encoding is visible on the state output, so the values are fixed.
  typedef enum logic [1:0] {
    ST_CLEAR = 2'b00,
    ST_PLOT  = 2'b01,
    ST_IDLE  = 2'b11
  } draw_state_e;

  typedef struct packed {
    logic               we;
    logic [X_W-1:0]     x;
    logic [Y_W-1:0]     y;
    logic [COLOR_W-1:0] color;
  } fb_wr_t;

endpackage : draw_pkg
`default_nettype wire

// File: rtl/draw_phase_timer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : draw_phase_timer                                             |
// | Description : Loadable phase cycle counter with a budget compare.          |
// |               The count returns to zero whenever load_i is high and        |
// |               advances while en_i is high; timeout_o flags the cycle in    |
// |               which the count equals limit_i (budget - 1).                 |
// | Ports       : clk, rst_n   - clock, asynchronous active-low reset          |
// |               load_i       - restart the count at zero                     |
// |               en_i         - count this cycle (phase active)               |
// |               limit_i      - last cycle index allowed in the phase         |
// |               timeout_o    - budget exhausted in this cycle                |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module draw_phase_timer #(
  parameter int CNT_W = 15
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic             en_i,
  input  logic [CNT_W-1:0] limit_i,
  output logic             timeout_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign timeout_o = en_i && (cnt_q == limit_i);

endmodule : draw_phase_timer
`default_nettype wire

// File: rtl/draw_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : draw_scheduler                                               |
// | Description : Frame sequencer and frame-buffer write arbiter for the VGA   |
// |               clear engine and sine plotter. Each frame period it runs     |
// |               CLEAR, then PLOT, then IDLE, bounding each phase by a cycle  |
// |               budget and forwarding only the granted client's pixels.     |
// | Ports       : clk, rst_n            - clock, async active-low reset        |
// |               man_in                - hold off new frame starts           |
// |               clr_* / plt_*         - client start/abort pulses, pixel     |
// |                                       stream and done inputs              |
// |               fb_we/x/y/color       - registered frame-buffer write port   |
// |               frame_tick            - last cycle of each frame period      |
// |               state                 - 00 CLEAR, 01 PLOT, 11 IDLE           |
// |               overrun               - sticky, set by any abort             |
// | Build option: DRAW_SCHED_STATS_EN adds saturating clr_abort_cnt,           |
// |               plt_abort_cnt and frames_cnt outputs.                        |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module draw_scheduler
  import draw_pkg::*;
#(
  parameter int FRAME_CYCLES = 500000,
  parameter int CLEAR_BUDGET = H_PIX * V_PIX,
  parameter int PLOT_BUDGET  = H_PIX
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               man_in,

  output logic               clr_start,
  output logic               clr_abort,
  input  logic               clr_valid,
  input  logic [X_W-1:0]     clr_x,
  input  logic [Y_W-1:0]     clr_y,
  input  logic [COLOR_W-1:0] clr_color,
  input  logic               clr_done,

  output logic               plt_start,
  output logic               plt_abort,
  input  logic               plt_valid,
  input  logic [X_W-1:0]     plt_x,
  input  logic [Y_W-1:0]     plt_y,
  input  logic [COLOR_W-1:0] plt_color,
  input  logic               plt_done,

  output logic               fb_we,
  output logic [X_W-1:0]     fb_x,
  output logic [Y_W-1:0]     fb_y,
  output logic [COLOR_W-1:0] fb_color,

  output logic               frame_tick,
  output logic [1:0]         state,
  output logic               overrun
`ifdef DRAW_SCHED_STATS_EN
  ,
  output logic [7:0]         clr_abort_cnt,
  output logic [7:0]         plt_abort_cnt,
  output logic [15:0]        frames_cnt
`endif
);

  localparam int FRAME_W    = (FRAME_CYCLES > 1) ? $clog2(FRAME_CYCLES) : 1;
  localparam int MAX_BUDGET = (CLEAR_BUDGET > PLOT_BUDGET) ? CLEAR_BUDGET : PLOT_BUDGET;
  localparam int PHASE_W    = (MAX_BUDGET > 1) ? $clog2(MAX_BUDGET) : 1;

  localparam logic [FRAME_W-1:0] FRAME_LAST = FRAME_W'(FRAME_CYCLES - 1);
  localparam logic [PHASE_W-1:0] CLR_LIMIT  = PHASE_W'(CLEAR_BUDGET - 1);
  localparam logic [PHASE_W-1:0] PLT_LIMIT  = PHASE_W'(PLOT_BUDGET - 1);

  // Both phases plus the start/exit handoffs must fit in one frame, so a
  // frame tick can only ever be seen while IDLE.
  if ((CLEAR_BUDGET < 1) || (PLOT_BUDGET < 1) ||
      (CLEAR_BUDGET + PLOT_BUDGET + 4 > FRAME_CYCLES)) begin : g_param_check
    $error("draw_scheduler: budgets must be >= 1 and CLEAR_BUDGET + PLOT_BUDGET + 4 <= FRAME_CYCLES");
  end

  draw_state_e        state_q, state_d;
  logic [FRAME_W-1:0] frame_cnt_q, frame_cnt_d;
  logic               clr_start_q, clr_start_d;
  logic               plt_start_q, plt_start_d;
  logic               overrun_q, overrun_d;
  fb_wr_t             wr_q, wr_d;

  logic               phase_active;
  logic               phase_exit;
  logic               phase_timeout;
  logic [PHASE_W-1:0] phase_limit;

  // ---------------------------------------------------------------------------
  // Free-running frame period counter (ignores man_in)
  // ---------------------------------------------------------------------------
  assign frame_tick  = (frame_cnt_q == FRAME_LAST);
  assign frame_cnt_d = frame_tick ? '0 : frame_cnt_q + FRAME_W'(1);

  // ---------------------------------------------------------------------------
  // Phase budget timer: held at zero in IDLE and reloaded on every phase
  // exit, so each phase sees cycle 0 on its first (start-pulse) cycle.
  // ---------------------------------------------------------------------------
  assign phase_active = (state_q != ST_IDLE);
  assign phase_limit  = (state_q == ST_PLOT) ? PLT_LIMIT : CLR_LIMIT;

  draw_phase_timer #(
    .CNT_W (PHASE_W)
  ) u_phase_timer (
    .clk       (clk),
    .rst_n     (rst_n),
    .load_i    (!phase_active || phase_exit),
    .en_i      (phase_active),
    .limit_i   (phase_limit),
    .timeout_o (phase_timeout)
  );

  // ---------------------------------------------------------------------------
  // Phase sequencer. Done wins over a coincident timeout, so the abort is
  // only raised when the budget runs out without the client finishing.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    phase_exit  = 1'b0;
    clr_start_d = 1'b0;
    plt_start_d = 1'b0;
    clr_abort   = 1'b0;
    plt_abort   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (frame_tick && !man_in) begin
          state_d     = ST_CLEAR;
          clr_start_d = 1'b1;
        end
      end
      ST_CLEAR: begin
        if (clr_done || phase_timeout) begin
          phase_exit  = 1'b1;
          state_d     = ST_PLOT;
          plt_start_d = 1'b1;
          clr_abort   = !clr_done;
        end
      end
      ST_PLOT: begin
        if (plt_done || phase_timeout) begin
          phase_exit = 1'b1;
          state_d    = ST_IDLE;
          plt_abort  = !plt_done;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign overrun_d = overrun_q || clr_abort || plt_abort;

  // ---------------------------------------------------------------------------
  // Write-port mux: selection follows the current phase, so the exit cycle
  // still forwards the outgoing client's pixel. Non-granted ports give zero.
  // ---------------------------------------------------------------------------
  always_comb begin
    wr_d = '0;
    case (state_q)
      ST_CLEAR: begin
        wr_d.we    = clr_valid;
        wr_d.x     = clr_x;
        wr_d.y     = clr_y;
        wr_d.color = clr_color;
      end
      ST_PLOT: begin
        wr_d.we    = plt_valid;
        wr_d.x     = plt_x;
        wr_d.y     = plt_y;
        wr_d.color = plt_color;
      end
      default: begin
        wr_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      frame_cnt_q <= '0;
      clr_start_q <= 1'b0;
      plt_start_q <= 1'b0;
      overrun_q   <= 1'b0;
      wr_q        <= '0;
    end else begin
      state_q     <= state_d;
      frame_cnt_q <= frame_cnt_d;
      clr_start_q <= clr_start_d;
      plt_start_q <= plt_start_d;
      overrun_q   <= overrun_d;
      wr_q        <= wr_d;
    end
  end

  assign clr_start = clr_start_q;
  assign plt_start = plt_start_q;
  assign overrun   = overrun_q;
  assign state     = state_q;
  assign fb_we     = wr_q.we;
  assign fb_x      = wr_q.x;
  assign fb_y      = wr_q.y;
  assign fb_color  = wr_q.color;

`ifdef DRAW_SCHED_STATS_EN
  // ---------------------------------------------------------------------------
  // Saturating event counters. A started frame is marked by the clear start
  // pulse, which only fires when a frame actually begins.
  // ---------------------------------------------------------------------------
  logic [7:0]  clr_abort_cnt_q;
  logic [7:0]  plt_abort_cnt_q;
  logic [15:0] frames_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clr_abort_cnt_q <= '0;
      plt_abort_cnt_q <= '0;
      frames_cnt_q    <= '0;
    end else begin
      if (clr_abort && (clr_abort_cnt_q != 8'hFF)) begin
        clr_abort_cnt_q <= clr_abort_cnt_q + 8'd1;
      end
      if (plt_abort && (plt_abort_cnt_q != 8'hFF)) begin
        plt_abort_cnt_q <= plt_abort_cnt_q + 8'd1;
      end
      if (clr_start_q && (frames_cnt_q != 16'hFFFF)) begin
        frames_cnt_q <= frames_cnt_q + 16'd1;
      end
    end
  end

  assign clr_abort_cnt = clr_abort_cnt_q;
  assign plt_abort_cnt = plt_abort_cnt_q;
  assign frames_cnt    = frames_cnt_q;
`endif

endmodule : draw_scheduler
`default_nettype wire

// File: tb/tb_draw_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_draw_scheduler                                            |
// | Description : Self-checking bench for draw_scheduler with FRAME_CYCLES=64, |
// |               CLEAR_BUDGET=20, PLOT_BUDGET=8. A table of per-frame         |
// |               scenarios drives the clients; expected write-port values are |
// |               queued when driven and compared one cycle later.             |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_draw_scheduler;

  localparam int FRAME_CYCLES = 64;
  localparam int CLEAR_BUDGET = 20;
  localparam int PLOT_BUDGET  = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        man_in = 1'b0;
  logic        clr_start, clr_abort, clr_valid, clr_done;
  logic [7:0]  clr_x, clr_y;
  logic [11:0] clr_color;
  logic        plt_start, plt_abort, plt_valid, plt_done;
  logic [7:0]  plt_x, plt_y;
  logic [11:0] plt_color;
  logic        fb_we;
  logic [7:0]  fb_x, fb_y;
  logic [11:0] fb_color;
  logic        frame_tick;
  logic [1:0]  state;
  logic        overrun;
`ifdef DRAW_SCHED_STATS_EN
  logic [7:0]  clr_abort_cnt, plt_abort_cnt;
  logic [15:0] frames_cnt;
`endif

  always #5 clk = ~clk;

  draw_scheduler #(
    .FRAME_CYCLES (FRAME_CYCLES),
    .CLEAR_BUDGET (CLEAR_BUDGET),
    .PLOT_BUDGET  (PLOT_BUDGET)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .man_in     (man_in),
    .clr_start  (clr_start),
    .clr_abort  (clr_abort),
    .clr_valid  (clr_valid),
    .clr_x      (clr_x),
    .clr_y      (clr_y),
    .clr_color  (clr_color),
    .clr_done   (clr_done),
    .plt_start  (plt_start),
    .plt_abort  (plt_abort),
    .plt_valid  (plt_valid),
    .plt_x      (plt_x),
    .plt_y      (plt_y),
    .plt_color  (plt_color),
    .plt_done   (plt_done),
    .fb_we      (fb_we),
    .fb_x       (fb_x),
    .fb_y       (fb_y),
    .fb_color   (fb_color),
    .frame_tick (frame_tick),
    .state      (state),
    .overrun    (overrun)
`ifdef DRAW_SCHED_STATS_EN
    ,
    .clr_abort_cnt (clr_abort_cnt),
    .plt_abort_cnt (plt_abort_cnt),
    .frames_cnt    (frames_cnt)
`endif
  );

  // One record per frame period. l1/l2 are the expected CLEAR/PLOT lengths
  // in cycles; done_at values are phase-cycle indices (-1 = never).
  typedef struct {
    logic start;
    int   clr_done_at;
    int   plt_done_at;
    logic man;
    logic noise;
    int   l1;
    int   l2;
    logic exp_clr_abort;
    logic exp_plt_abort;
    logic exp_overrun;
  } frame_rec_t;

  typedef struct packed {
    logic        we;
    logic [7:0]  x;
    logic [7:0]  y;
    logic [11:0] c;
  } fbw_t;

  localparam int NREC = 11;
  frame_rec_t recs [NREC];
  fbw_t       sbq [$];
  int         checks = 0;
  int         failures = 0;
  logic       ovr_exp = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic in_clr(input frame_rec_t r, input int j);
    return r.start && (j < r.l1);
  endfunction

  function automatic logic in_plt(input frame_rec_t r, input int j);
    return r.start && (j >= r.l1) && (j < r.l1 + r.l2);
  endfunction

  function automatic logic abort_expected(input frame_rec_t r, input int j);
    return (in_clr(r, j) && r.exp_clr_abort && (j == r.l1 - 1)) ||
           (in_plt(r, j) && r.exp_plt_abort && (j == r.l1 + r.l2 - 1));
  endfunction

  // Apply the client inputs for frame cycle j and queue the write the DUT
  // must present one cycle later.
  task automatic drive(input frame_rec_t r, input logic prev_man, input int j);
    logic ic, ip;
    ic = in_clr(r, j);
    ip = in_plt(r, j);
    man_in    = (j < 5) ? prev_man : r.man;
    clr_valid = ((j % 4) != 3);
    clr_x     = clr_valid ? 8'h11 : 8'h00;
    clr_y     = clr_valid ? 8'(j) : 8'h00;
    clr_color = clr_valid ? (12'h100 | 12'(j)) : 12'h000;
    plt_valid = ((j % 3) != 1);
    plt_x     = plt_valid ? 8'h22 : 8'h00;
    plt_y     = plt_valid ? 8'(j + 100) : 8'h00;
    plt_color = plt_valid ? (12'h200 | 12'(j)) : 12'h000;
    clr_done  = (ic && (j == r.clr_done_at)) || (r.noise && !ic);
    plt_done  = (ip && ((j - r.l1) == r.plt_done_at)) || (r.noise && !ip);
    if (ic)      sbq.push_back({clr_valid, clr_x, clr_y, clr_color});
    else if (ip) sbq.push_back({plt_valid, plt_x, plt_y, plt_color});
    else         sbq.push_back('0);
  endtask

  task automatic check_cycle(input frame_rec_t r, input int j);
    logic [1:0] exp_state;
    fbw_t       e;
    if (in_clr(r, j))      exp_state = 2'b00;
    else if (in_plt(r, j)) exp_state = 2'b01;
    else                   exp_state = 2'b11;
    chk("state", 32'(state), 32'(exp_state));
    chk("frame_tick", 32'(frame_tick), 32'(j == FRAME_CYCLES - 1));
    chk("clr_start", 32'(clr_start), 32'(r.start && (j == 0)));
    chk("plt_start", 32'(plt_start), 32'(in_plt(r, j) && (j == r.l1)));
    chk("clr_abort", 32'(clr_abort), 32'(in_clr(r, j) && r.exp_clr_abort && (j == r.l1 - 1)));
    chk("plt_abort", 32'(plt_abort), 32'(in_plt(r, j) && r.exp_plt_abort && (j == r.l1 + r.l2 - 1)));
    chk("overrun", 32'(overrun), 32'(ovr_exp));
    if (sbq.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL scoreboard: no expected write queued at t=%0t", $time);
    end else begin
      e = sbq.pop_front();
      chk("fb_port", 32'({fb_we, fb_x, fb_y, fb_color}), 32'(e));
    end
  endtask

  // Entered 1 time unit after a rising edge; leaves 1 unit after the next.
  task automatic run_cycle(input frame_rec_t r, input logic prev_man, input int j);
    logic ab;
    drive(r, prev_man, j);
    #1;
    check_cycle(r, j);
    ab = abort_expected(r, j);
    @(posedge clk);
    #1;
    if (ab) ovr_exp = 1'b1;
  endtask

  initial begin
    //           start cd  pd  man noise l1  l2  cab pab ovr
    recs[0]  = '{1'b0, -1, -1, 1'b0, 1'b0,  0, 0, 1'b0, 1'b0, 1'b0}; // post-reset idle
    recs[1]  = '{1'b1, 10,  5, 1'b0, 1'b0, 11, 6, 1'b0, 1'b0, 1'b0}; // normal frame
    recs[2]  = '{1'b1,  3,  2, 1'b0, 1'b1,  4, 3, 1'b0, 1'b0, 1'b0}; // off-grant done noise
    recs[3]  = '{1'b1, 10,  7, 1'b0, 1'b0, 11, 8, 1'b0, 1'b0, 1'b0}; // plot done == timeout
    recs[4]  = '{1'b1, -1,  5, 1'b0, 1'b0, 20, 6, 1'b1, 1'b0, 1'b1}; // clear timeout
    recs[5]  = '{1'b1, 19,  0, 1'b0, 1'b0, 20, 1, 1'b0, 1'b0, 1'b1}; // clear done == timeout
    recs[6]  = '{1'b1, 10,  5, 1'b1, 1'b0, 11, 6, 1'b0, 1'b0, 1'b1}; // man_in rises mid-CLEAR
    recs[7]  = '{1'b0, -1, -1, 1'b1, 1'b0,  0, 0, 1'b0, 1'b0, 1'b1}; // held
    recs[8]  = '{1'b0, -1, -1, 1'b0, 1'b0,  0, 0, 1'b0, 1'b0, 1'b1}; // released mid-frame
    recs[9]  = '{1'b1,  2, -1, 1'b0, 1'b0,  3, 8, 1'b0, 1'b1, 1'b1}; // plot timeout
    recs[10] = '{1'b1,  2, -1, 1'b0, 1'b0,  3, 8, 1'b0, 1'b1, 1'b1}; // reset during PLOT

    clr_valid = 1'b0; clr_x = '0; clr_y = '0; clr_color = '0; clr_done = 1'b0;
    plt_valid = 1'b1; plt_x = 8'h22; plt_y = '0; plt_color = '0; plt_done = 1'b0;
    clr_valid = 1'b1; clr_x = 8'h11;

    // Reset state while held in reset
    repeat (3) @(posedge clk);
    #1;
    chk("rst_state", 32'(state), 32'(2'b11));
    chk("rst_fb", 32'({fb_we, fb_x, fb_y, fb_color}), 32'd0);
    chk("rst_starts", 32'({clr_start, plt_start}), 32'd0);
    chk("rst_aborts", 32'({clr_abort, plt_abort}), 32'd0);
    chk("rst_overrun", 32'(overrun), 32'd0);
    chk("rst_tick", 32'(frame_tick), 32'd0);

    rst_n = 1'b1;
    sbq.push_back('0);
    for (int k = 0; k < NREC - 1; k++) begin
      for (int j = 0; j < FRAME_CYCLES; j++) begin
        run_cycle(recs[k], (k == 0) ? 1'b0 : recs[k-1].man, j);
      end
      chk("frame_end_overrun", 32'(overrun), 32'(recs[k].exp_overrun));
    end

    // Asynchronous reset at PLOT phase cycle 3 (frame cycle l1 + 3)
    for (int j = 0; j < recs[10].l1 + 3; j++) begin
      run_cycle(recs[10], recs[9].man, j);
    end
    drive(recs[10], recs[9].man, recs[10].l1 + 3);
    #1;
    chk("pre_rst_state", 32'(state), 32'(2'b01));
    chk("pre_rst_fb_we", 32'(fb_we), 32'(sbq[0].we));
    rst_n = 1'b0;
    #1;
    chk("arst_state", 32'(state), 32'(2'b11));
    chk("arst_fb", 32'({fb_we, fb_x, fb_y, fb_color}), 32'd0);
    chk("arst_plt_abort", 32'(plt_abort), 32'd0);
    chk("arst_overrun", 32'(overrun), 32'd0);
    sbq.delete();
    plt_done = 1'b0;
    clr_done = 1'b0;
    man_in   = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    // Frame counter restarts at zero: tick after exactly FRAME_CYCLES-1 edges.
    for (int n = 0; n < FRAME_CYCLES; n++) begin
      #1;
      chk("post_rst_tick", 32'(frame_tick), 32'(n == FRAME_CYCLES - 1));
      chk("post_rst_state", 32'(state), 32'(2'b11));
      chk("post_rst_idle_fb", 32'({fb_we, fb_x}), 32'd0);
      chk("post_rst_plt_abort", 32'(plt_abort), 32'd0);
      @(posedge clk);
    end
    #1;
    chk("post_rst_clr_start", 32'(clr_start), 32'd1);
    chk("post_rst_clear", 32'(state), 32'(2'b00));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_draw_scheduler
`default_nettype wire
